// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multicycle rysy control FSM.
package multicycle_ctrl_pkg;

  localparam int unsigned REG_LEN = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned IMM_W   = 3;
  localparam int unsigned WB_W    = 2;
  localparam int unsigned ST_W    = 3;

  // Immediate mux select encodings
  localparam logic [IMM_W-1:0] IMM_J       = 3'b000;
  localparam logic [IMM_W-1:0] IMM_U       = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B       = 3'b010;
  localparam logic [IMM_W-1:0] IMM_S       = 3'b011;
  localparam logic [IMM_W-1:0] IMM_I       = 3'b100;
  localparam logic [IMM_W-1:0] IMM_DEFAULT = 3'b101;

  // RV32I major opcodes
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // Write-back source select
  localparam logic [WB_W-1:0] WB_ALU  = 2'd0;
  localparam logic [WB_W-1:0] WB_LOAD = 2'd1;
  localparam logic [WB_W-1:0] WB_PC4  = 2'd2;
  localparam logic [WB_W-1:0] WB_IMM  = 2'd3;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Sequencing class: decides the path after EXEC
  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_LOAD   = 2'd2,
    CLS_STORE  = 2'd3
  } cls_t;

  typedef struct packed {
    logic [IMM_W-1:0] imm_type;
    logic [WB_W-1:0]  wb_sel;
    logic             alu_src_a_pc;
    logic             alu_src_b_imm;
    cls_t             cls;
    logic             illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    imm_type:      IMM_DEFAULT,
    wb_sel:        WB_ALU,
    alu_src_a_pc:  1'b0,
    alu_src_b_imm: 1'b0,
    cls:           CLS_ALU,
    illegal:       1'b0
  };

endpackage

// File: rtl/multicycle_ctrl_opcode_decode.sv
// Combinational opcode decoder: opcode -> datapath selects and sequencing class.
module multicycle_ctrl_opcode_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  // Map each RV32I major opcode to its controls; anything else is illegal
  always_comb begin
    dec = DEC_RESET;
    case (opcode)
      OPC_LUI: begin
        dec.imm_type = IMM_U;
        dec.wb_sel   = WB_IMM;
      end
      OPC_AUIPC: begin
        dec.imm_type      = IMM_U;
        dec.alu_src_a_pc  = 1'b1;
        dec.alu_src_b_imm = 1'b1;
      end
      OPC_JAL: begin
        dec.imm_type      = IMM_J;
        dec.wb_sel        = WB_PC4;
        dec.alu_src_a_pc  = 1'b1;
        dec.alu_src_b_imm = 1'b1;
      end
      OPC_JALR: begin
        dec.imm_type      = IMM_I;
        dec.wb_sel        = WB_PC4;
        dec.alu_src_b_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm_type      = IMM_B;
        dec.alu_src_a_pc  = 1'b1;
        dec.alu_src_b_imm = 1'b1;
        dec.cls           = CLS_BRANCH;
      end
      OPC_LOAD: begin
        dec.imm_type      = IMM_I;
        dec.wb_sel        = WB_LOAD;
        dec.alu_src_b_imm = 1'b1;
        dec.cls           = CLS_LOAD;
      end
      OPC_STORE: begin
        dec.imm_type      = IMM_S;
        dec.alu_src_b_imm = 1'b1;
        dec.cls           = CLS_STORE;
      end
      OPC_OPIMM: begin
        dec.imm_type      = IMM_I;
        dec.alu_src_b_imm = 1'b1;
      end
      OPC_OP: begin
        dec.imm_type = IMM_DEFAULT;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle rysy core: FETCH/DECODE/EXEC/MEM/WB.
// Build option RYSY_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP
// and add the trap output; otherwise they retire as a NOP.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        instr_req,
  output logic        ir_load,
  output logic [2:0]  imm_type,
  output logic        alu_src_b_imm,
  output logic        alu_src_a_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  wb_sel,
  output logic        reg_we,
  output logic        pc_write,
  output logic        pc_sel,
`ifdef RYSY_ILLEGAL_TRAP_EN
  output logic        trap,
`endif
  output logic [2:0]  state
);

  state_t state_q, state_d;
  dec_t   dec_d, dec_q;

  // Only the opcode field drives control; the rest of the word feeds the datapath
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr[INSTR_W-1:OPC_W];

  multicycle_ctrl_opcode_decode u_dec (
    .opcode (instr[OPC_W-1:0]),
    .dec    (dec_d)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Decoded opcode captured alongside the IR, so imm_type is valid throughout DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dec_q <= DEC_RESET;
    else if (ir_load) dec_q <= dec_d;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_d       = state_q;
    instr_req     = 1'b0;
    ir_load       = 1'b0;
    alu_src_a_pc  = 1'b0;
    alu_src_b_imm = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    wb_sel        = WB_ALU;
    reg_we        = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_req = rst_n;
        if (instr_valid && rst_n) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
`ifdef RYSY_ILLEGAL_TRAP_EN
        state_d = dec_q.illegal ? ST_TRAP : ST_EXEC;
`else
        state_d = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        alu_src_a_pc  = dec_q.alu_src_a_pc;
        alu_src_b_imm = dec_q.alu_src_b_imm;
        if (dec_q.illegal) begin
          pc_write = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          case (dec_q.cls)
            CLS_BRANCH: begin
              pc_write = 1'b1;
              pc_sel   = branch_taken;
              state_d  = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            default:             state_d = ST_WB;
          endcase
        end
      end
      ST_MEM: begin
        alu_src_a_pc  = dec_q.alu_src_a_pc;
        alu_src_b_imm = dec_q.alu_src_b_imm;
        mem_req       = 1'b1;
        mem_we        = (dec_q.cls == CLS_STORE);
        if (mem_ready) begin
          if (dec_q.cls == CLS_STORE) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        alu_src_a_pc  = dec_q.alu_src_a_pc;
        alu_src_b_imm = dec_q.alu_src_b_imm;
        reg_we        = 1'b1;
        pc_write      = 1'b1;
        wb_sel        = dec_q.wb_sel;
        pc_sel        = (dec_q.wb_sel == WB_PC4);
        state_d       = ST_FETCH;
      end
`ifdef RYSY_ILLEGAL_TRAP_EN
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign imm_type = dec_q.imm_type;
  assign state    = ST_W'(state_q);

`ifdef RYSY_ILLEGAL_TRAP_EN
  assign trap = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instructions plus
// hand-written reset-abort and illegal-opcode sequences.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid, mem_ready, branch_taken;
  logic        instr_req, ir_load, alu_src_b_imm, alu_src_a_pc;
  logic        mem_req, mem_we, reg_we, pc_write, pc_sel;
  logic [2:0]  imm_type, state;
  logic [1:0]  wb_sel;
`ifdef RYSY_ILLEGAL_TRAP_EN
  logic        trap;
`endif

  multicycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .instr_req     (instr_req),
    .ir_load       (ir_load),
    .imm_type      (imm_type),
    .alu_src_b_imm (alu_src_b_imm),
    .alu_src_a_pc  (alu_src_a_pc),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .wb_sel        (wb_sel),
    .reg_we        (reg_we),
    .pc_write      (pc_write),
    .pc_sel        (pc_sel),
`ifdef RYSY_ILLEGAL_TRAP_EN
    .trap          (trap),
`endif
    .state         (state)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] I_J = 3'b000, I_U = 3'b001, I_B = 3'b010,
                         I_S = 3'b011, I_I = 3'b100, I_D = 3'b101;
  localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_NOP = 4;

  typedef struct packed {
    logic [2:0] state;
    logic       instr_req;
    logic       ir_load;
    logic [2:0] imm_type;
    logic       a_pc;
    logic       b_imm;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] wb_sel;
    logic       reg_we;
    logic       pc_write;
    logic       pc_sel;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          kind;
    logic        bt;
    int          fetch_wait;
    int          mem_wait;
    logic [2:0]  imm;
    logic [1:0]  wb;
    logic        pcsel;
    logic        a_pc;
    logic        b_imm;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t sb_q[$];
  logic [2:0] prev_imm;
  vec_t vecs[12];

  function automatic vec_t mk(string nm, logic [31:0] ins, int k, logic bt, int fw, int mw,
                              logic [2:0] imm, logic [1:0] wb, logic ps, logic ap, logic bi);
    vec_t v;
    v.name = nm; v.instr = ins; v.kind = k; v.bt = bt; v.fetch_wait = fw; v.mem_wait = mw;
    v.imm = imm; v.wb = wb; v.pcsel = ps; v.a_pc = ap; v.b_imm = bi;
    return v;
  endfunction

  function automatic obs_t blank(logic [2:0] st, logic [2:0] imm);
    obs_t o;
    o = '0;
    o.state = st;
    o.imm_type = imm;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state = state; o.instr_req = instr_req; o.ir_load = ir_load; o.imm_type = imm_type;
    o.a_pc = alu_src_a_pc; o.b_imm = alu_src_b_imm; o.mem_req = mem_req; o.mem_we = mem_we;
    o.wb_sel = wb_sel; o.reg_we = reg_we; o.pc_write = pc_write; o.pc_sel = pc_sel;
    return o;
  endfunction

  // Push expectation, let inputs settle, pop and compare, then advance one cycle
  task automatic step(input obs_t e, input string nm);
    obs_t got, exp_o;
    sb_q.push_back(e);
    #2;
    got = sample();
    exp_o = sb_q.pop_front();
    n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", nm, $time, got, exp_o);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    obs_t e;
    branch_taken = v.bt;
    mem_ready    = 1'b1;
    for (int i = 0; i < v.fetch_wait; i++) begin
      instr = 32'hDEAD_BEEF; instr_valid = 1'b0;
      e = blank(3'd0, prev_imm); e.instr_req = 1'b1;
      step(e, {v.name, "/fetch_wait"});
    end
    instr = v.instr; instr_valid = 1'b1;
    e = blank(3'd0, prev_imm); e.instr_req = 1'b1; e.ir_load = 1'b1;
    step(e, {v.name, "/fetch"});
    instr = 32'h0000_0063;
    step(blank(3'd1, v.imm), {v.name, "/decode"});
    e = blank(3'd2, v.imm); e.a_pc = v.a_pc; e.b_imm = v.b_imm;
    if (v.kind == K_BR)  begin e.pc_write = 1'b1; e.pc_sel = v.bt; end
    if (v.kind == K_NOP) begin e.pc_write = 1'b1; end
    step(e, {v.name, "/exec"});
    if (v.kind == K_LD || v.kind == K_ST) begin
      for (int i = 0; i <= v.mem_wait; i++) begin
        mem_ready = (i == v.mem_wait);
        e = blank(3'd3, v.imm); e.a_pc = v.a_pc; e.b_imm = v.b_imm; e.mem_req = 1'b1;
        e.mem_we = (v.kind == K_ST);
        if (v.kind == K_ST && i == v.mem_wait) e.pc_write = 1'b1;
        step(e, {v.name, "/mem"});
      end
      mem_ready = 1'b1;
    end
    if (v.kind == K_ALU || v.kind == K_LD) begin
      e = blank(3'd4, v.imm); e.a_pc = v.a_pc; e.b_imm = v.b_imm;
      e.reg_we = 1'b1; e.pc_write = 1'b1; e.wb_sel = v.wb; e.pc_sel = v.pcsel;
      step(e, {v.name, "/wb"});
    end
    prev_imm = v.imm;
    instr_valid = 1'b0;
  endtask

`ifdef RYSY_ILLEGAL_TRAP_EN
  task automatic check_trap(input logic exp_t, input string nm);
    n_cmp++;
    if (trap !== exp_t) begin
      n_bad++;
      $display("FAIL %s: trap got %b required %b", nm, trap, exp_t);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    vecs[0]  = mk("addi",   32'h0050_0093, K_ALU, 1'b0, 0, 0, I_I, 2'd0, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk("lw_w3",  32'h0000_2103, K_LD,  1'b0, 0, 2, I_I, 2'd1, 1'b0, 1'b0, 1'b1);
    vecs[2]  = mk("sw",     32'h0010_2023, K_ST,  1'b0, 0, 0, I_S, 2'd0, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk("beq_t",  32'h0000_0463, K_BR,  1'b1, 0, 0, I_B, 2'd0, 1'b0, 1'b1, 1'b1);
    vecs[4]  = mk("beq_nt", 32'h0000_0463, K_BR,  1'b0, 0, 0, I_B, 2'd0, 1'b0, 1'b1, 1'b1);
    vecs[5]  = mk("add",    32'h0020_81B3, K_ALU, 1'b0, 0, 0, I_D, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk("lui",    32'h1234_50B7, K_ALU, 1'b0, 0, 0, I_U, 2'd3, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk("auipc",  32'h0000_1097, K_ALU, 1'b0, 0, 0, I_U, 2'd0, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk("jalr",   32'h0000_80E7, K_ALU, 1'b0, 0, 0, I_I, 2'd2, 1'b1, 1'b0, 1'b1);
    vecs[9]  = mk("lw_fw",  32'h0000_2103, K_LD,  1'b0, 2, 0, I_I, 2'd1, 1'b0, 1'b0, 1'b1);
    vecs[10] = mk("sw_w2",  32'h0010_2023, K_ST,  1'b0, 1, 1, I_S, 2'd0, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk("jal",    32'h0100_00EF, K_ALU, 1'b0, 0, 0, I_J, 2'd2, 1'b1, 1'b1, 1'b1);

    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    step(blank(3'd0, I_D), "reset");
    rst_n = 1'b1;
    prev_imm = I_D;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted in EXEC of an addi aborts it with no pc_write/reg_we
    instr = 32'h0050_0093; instr_valid = 1'b1;
    e = blank(3'd0, prev_imm); e.instr_req = 1'b1; e.ir_load = 1'b1;
    step(e, "abort/fetch");
    step(blank(3'd1, I_I), "abort/decode");
    rst_n = 1'b0;
    step(blank(3'd0, I_D), "abort/in_reset");
    step(blank(3'd0, I_D), "abort/in_reset2");
    rst_n = 1'b1; instr_valid = 1'b0;
    e = blank(3'd0, I_D); e.instr_req = 1'b1;
    step(e, "abort/release");
    prev_imm = I_D;

`ifdef RYSY_ILLEGAL_TRAP_EN
    instr = 32'h0000_007F; instr_valid = 1'b1; mem_ready = 1'b1;
    e = blank(3'd0, prev_imm); e.instr_req = 1'b1; e.ir_load = 1'b1;
    step(e, "trap/fetch");
    #2 check_trap(1'b0, "trap/decode");
    step(blank(3'd1, I_D), "trap/decode");
    for (int i = 0; i < 4; i++) begin
      #2 check_trap(1'b1, "trap/hold");
      step(blank(3'd5, I_D), "trap/hold");
    end
    rst_n = 1'b0; instr_valid = 1'b0;
    #2 check_trap(1'b0, "trap/reset");
    step(blank(3'd0, I_D), "trap/reset");
    rst_n = 1'b1;
`else
    run_vec(mk("illegal_nop", 32'h0000_007F, K_NOP, 1'b0, 0, 0, I_D, 2'd0, 1'b0, 1'b0, 1'b0));
`endif

    // Normal operation resumes after the abort / illegal case
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle rysy core. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the immediate-mux select, PC update, register-file write, ALU operand select and data-memory handshake. Sits between the instruction/data memory ports and the datapath (imm mux, ALU, regfile, PC register).

Parameters:
XLEN, `REG_LEN, datapath width (instr fixed at 32 bits)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
instr  in  32  instruction word from instruction memory
instr_valid  in  1  instr is valid this cycle (fetch ack)
mem_ready  in  1  data-memory ack for load/store
branch_taken  in  1  ALU compare result, sampled in EXEC
instr_req  out  1  fetch request
ir_load  out  1  latch instr into IR and internal opcode register
imm_type  out  3  immediate mux select (IMM_J/U/B/S/I/DEFAULT)
alu_src_b_imm  out  1  1: ALU operand B = imm, 0: rs2
alu_src_a_pc  out  1  1: ALU operand A = PC (AUIPC/JAL/branch target)
mem_req  out  1  data-memory request
mem_we  out  1  1: store, 0: load (valid with mem_req)
wb_sel  out  2  0: ALU, 1: load data, 2: PC+4, 3: imm (LUI)
reg_we  out  1  register-file write strobe, one cycle
pc_write  out  1  PC update strobe, exactly one per instruction
pc_sel  out  1  0: PC+4, 1: ALU result (jump/taken-branch target)
state  out  3  current FSM state (debug)

Behaviour:
- Async reset (rst_n=0): state=FETCH; imm_type=IMM_DEFAULT; every other output 0. Reset mid-instruction aborts it; no pc_write/reg_we issued.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: instr_req=1 held until instr_valid; on instr_valid, ir_load=1 same cycle, opcode = instr[6:0] registered -> DECODE. instr_valid outside FETCH ignored.
- DECODE (1 cycle): imm_type registered from opcode: LUI/AUIPC->U, JAL->J, JALR/LOAD/OP-IMM->I, BRANCH->B, STORE->S, OP->DEFAULT. imm_type stays stable until next DECODE.
- EXEC (1 cycle): ALU selects set per opcode. BRANCH: pc_write=1, pc_sel=branch_taken -> FETCH. LOAD/STORE -> MEM. Others -> WB.
- MEM: mem_req=1, mem_we=(STORE), held until mem_ready. STORE: on mem_ready, pc_write=1, pc_sel=0 -> FETCH. LOAD: on mem_ready -> WB. mem_ready outside MEM ignored.
- WB (1 cycle): reg_we=1, pc_write=1. wb_sel: OP/OP-IMM/AUIPC=0, LOAD=1, JAL/JALR=2, LUI=3. pc_sel=1 for JAL/JALR, else 0 -> FETCH.
- Minimum latencies with zero-wait memories (instr_valid/mem_ready high on first request cycle): BRANCH 3 cycles; STORE, OP, OP-IMM, LUI, AUIPC, JAL, JALR 4 cycles; LOAD 5 cycles.
- Every output except imm_type, alu_src_a_pc, alu_src_b_imm and state is a single-state strobe, 0 in all other states. ALU selects hold from EXEC through WB.
- Unsupported opcode: see Optional Feature.

Optional Feature:
RYSY_ILLEGAL_TRAP_EN. Defined: illegal opcode in DECODE -> TRAP. TRAP holds, all strobes 0, until reset. Extra output trap (1 bit), 1 only in TRAP. Undefined: illegal opcode is treated as NOP. DECODE -> EXEC -> FETCH with pc_write=1, pc_sel=0 in EXEC. No reg_we, no trap port.

Decomposition:
- rysy_pkg.vh holds the shared constants: IMM_J..IMM_DEFAULT encodings (000..101), RV32I opcode constants, state encodings, wb_sel encodings, REG_LEN.
- One sub-module, opcode_decode. It is combinational: opcode -> {imm_type, wb_sel, alu_src_a_pc, alu_src_b_imm, class, illegal}. The FSM registers its results.

Test Plan:
- addi x1,x0,5 (0x00500093), zero-wait -> imm_type=100 from cycle 2; reg_we & pc_write in cycle 4, wb_sel=0, pc_sel=0.
- lw x2,0(x0) (0x00002103), mem_ready delayed 3 cycles -> mem_req held 3 cycles, mem_we=0; WB reg_we with wb_sel=1; total 7 cycles.
- sw x1,0(x0) (0x00102023) -> imm_type=011, mem_req & mem_we=1; pc_write on mem_ready cycle; reg_we never asserted.
- beq (0x00000463) with branch_taken=1, then =0 -> imm_type=010; pc_write in EXEC, pc_sel=1 then 0; 3 cycles each.
- jal x1,16 (0x010000EF) -> imm_type=000, wb_sel=2, pc_sel=1, reg_we & pc_write in same cycle. Then rst_n low during EXEC of next instr -> state=FETCH, all strobes 0, imm_type=101 immediately.
- opcode 0x7F (0x0000007F) -> with RYSY_ILLEGAL_TRAP_EN: trap=1, state=5, stuck until reset. Without it: pc_write with pc_sel=0 after 3 cycles, no reg_we.
